// File: rtl/mem_trace_lane_serializer.sv
// Captures one multi-lane memory trace snapshot, stamps it with a cycle count,
// and issues its valid lanes one record per handshake in ascending lane order.
module mem_trace_lane_serializer #(
  parameter int NUM_LANES     = 4,
  parameter int SOURCE_WIDTH  = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int LOGSIZE_WIDTH = 8,
  parameter int LANE_ID_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LANES-1:0]               in_valid,
  input  logic [SOURCE_WIDTH*NUM_LANES-1:0]  in_source,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    in_address,
  input  logic [NUM_LANES-1:0]               in_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] in_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]    in_data,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_cycle,
  output logic [LANE_ID_WIDTH-1:0]           out_lane_id,
  output logic [SOURCE_WIDTH-1:0]            out_source,
  output logic [DATA_WIDTH-1:0]              out_address,
  output logic                               out_is_store,
  output logic [LOGSIZE_WIDTH-1:0]           out_size,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               busy,
  output logic [31:0]                        stall_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                             state_r, state_n;
  logic [NUM_LANES-1:0]               pend_r, pend_n;
  logic [DATA_WIDTH-1:0]              cycle_ctr_r;
  logic [DATA_WIDTH-1:0]              held_cycle_r;
  logic [31:0]                        stall_count_r;
  logic [SOURCE_WIDTH*NUM_LANES-1:0]  src_r;
  logic [DATA_WIDTH*NUM_LANES-1:0]    addr_r;
  logic [NUM_LANES-1:0]               store_r;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] size_r;
  logic [DATA_WIDTH*NUM_LANES-1:0]    data_r;

  logic [LANE_ID_WIDTH-1:0]           sel_s;
  logic [NUM_LANES-1:0]               sel_mask_s;
  logic [NUM_LANES-1:0]               pend_cleared_s;
  logic                               one_left_s;
  logic                               in_ready_s;
  logic                               fire_s;

  // Lowest set pending bit: scan high to low so the lowest index wins last.
  always_comb begin
    sel_s = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      sel_s = pend_r[i] ? LANE_ID_WIDTH'(i) : sel_s;
    end
  end

  assign sel_mask_s     = NUM_LANES'(1) << sel_s;
  assign pend_cleared_s = pend_r & ~sel_mask_s;
  assign one_left_s     = (pend_r != '0) && ((pend_r & (pend_r - NUM_LANES'(1))) == '0);
  assign in_ready_s     = (state_r == IDLE) || ((state_r == DRAIN) && one_left_s && out_ready);
  assign fire_s         = (|in_valid) && in_ready_s;

  // Next-state and pending-mask update; a capture on the last drain beat replaces the mask.
  always_comb begin
    state_n = state_r;
    pend_n  = pend_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_n = DRAIN;
          pend_n  = in_valid;
        end else begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (fire_s) begin
          state_n = DRAIN;
          pend_n  = in_valid;
        end else if (out_ready) begin
          pend_n  = pend_cleared_s;
          state_n = (pend_cleared_s == '0) ? IDLE : DRAIN;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
        pend_n  = '0;
      end
    endcase
  end

  // State, counters and captured snapshot fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pend_r        <= '0;
      cycle_ctr_r   <= '0;
      held_cycle_r  <= '0;
      stall_count_r <= 32'd0;
      src_r         <= '0;
      addr_r        <= '0;
      store_r       <= '0;
      size_r        <= '0;
      data_r        <= '0;
    end else begin
      state_r     <= state_n;
      pend_r      <= pend_n;
      cycle_ctr_r <= cycle_ctr_r + DATA_WIDTH'(1);
      if ((|in_valid) && !in_ready_s && (stall_count_r != 32'hFFFF_FFFF)) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
      if (fire_s) begin
        held_cycle_r <= cycle_ctr_r;
        src_r        <= in_source;
        addr_r       <= in_address;
        store_r      <= in_is_store;
        size_r       <= in_size;
        data_r       <= in_data;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = (state_r == DRAIN);
  assign busy         = (state_r == DRAIN);
  assign stall_count  = stall_count_r;
  assign out_cycle    = held_cycle_r;
  assign out_lane_id  = sel_s;
  assign out_source   = src_r[int'(sel_s) * SOURCE_WIDTH +: SOURCE_WIDTH];
  assign out_address  = addr_r[int'(sel_s) * DATA_WIDTH +: DATA_WIDTH];
  assign out_is_store = store_r[sel_s];
  assign out_size     = size_r[int'(sel_s) * LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
  assign out_data     = data_r[int'(sel_s) * DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_mem_trace_lane_serializer.sv
// Bench for mem_trace_lane_serializer: scoreboard of expected records plus
// a table of snapshots and hand-written corner-case sequences.
module tb_mem_trace_lane_serializer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   in_valid = 4'b0;
  logic [127:0] in_source = '0;
  logic [255:0] in_address = '0;
  logic [3:0]   in_is_store = 4'b0;
  logic [31:0]  in_size = '0;
  logic [255:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_cycle;
  logic [1:0]   out_lane_id;
  logic [31:0]  out_source;
  logic [63:0]  out_address;
  logic         out_is_store;
  logic [7:0]   out_size;
  logic [63:0]  out_data;
  logic         busy;
  logic [31:0]  stall_count;

  mem_trace_lane_serializer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_source(in_source),
    .in_address(in_address), .in_is_store(in_is_store), .in_size(in_size),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_cycle(out_cycle), .out_lane_id(out_lane_id),
    .out_source(out_source), .out_address(out_address), .out_is_store(out_is_store),
    .out_size(out_size), .out_data(out_data), .busy(busy), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  lane;
    logic [31:0] src;
    logic [63:0] addr;
    logic        store;
    logic [7:0]  size;
    logic [63:0] data;
    logic [63:0] cyc;
  } rec_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] store;
    logic       rdy_always;
    int         exp_count;
    int         exp_first;
  } vec_t;

  rec_t        q[$];
  logic [63:0] cyc_m;
  logic [31:0] stall_m;
  int          n_checks = 0;
  int          n_err = 0;
  int          hs_cnt;
  int          first_lane;

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc_m <= 64'd0;
    else        cyc_m <= cyc_m + 64'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_snap(input logic [3:0] valid, input logic [3:0] store, input int tag);
    for (int n = 0; n < 4; n++) begin
      in_source[n*32 +: 32]  = 32'(tag * 16 + n);
      in_address[n*64 +: 64] = 64'h1000 + 64'(n) + 64'(tag) * 64'h100;
      in_size[n*8 +: 8]      = 8'(n + 1);
      in_data[n*64 +: 64]    = {$urandom, $urandom};
    end
    in_valid    = valid;
    in_is_store = store;
  endtask

  // One cycle: check outputs against the model, update the model, advance to next negedge.
  task automatic tick();
    logic exp_valid, exp_ready;
    rec_t h, r;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    chk("busy", {63'd0, busy}, {63'd0, exp_valid});
    chk("stall_count", {32'd0, stall_count}, {32'd0, stall_m});
    if (exp_valid) begin
      h = q[0];
      chk("lane_id", {62'd0, out_lane_id}, {62'd0, h.lane});
      chk("source", {32'd0, out_source}, {32'd0, h.src});
      chk("address", out_address, h.addr);
      chk("is_store", {63'd0, out_is_store}, {63'd0, h.store});
      chk("size", {56'd0, out_size}, {56'd0, h.size});
      chk("data", out_data, h.data);
      chk("cycle", out_cycle, h.cyc);
      if (out_ready) begin
        void'(q.pop_front());
        hs_cnt++;
        if (first_lane < 0) first_lane = int'(out_lane_id);
      end
    end
    if ((|in_valid) && exp_ready) begin
      for (int n = 0; n < 4; n++) begin
        if (in_valid[n]) begin
          r.lane  = 2'(n);
          r.src   = in_source[n*32 +: 32];
          r.addr  = in_address[n*64 +: 64];
          r.store = in_is_store[n];
          r.size  = in_size[n*8 +: 8];
          r.data  = in_data[n*64 +: 64];
          r.cyc   = cyc_m;
          q.push_back(r);
        end
      end
    end else if ((|in_valid) && stall_m != 32'hFFFF_FFFF) begin
      stall_m = stall_m + 32'd1;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {32'd0, stall_count}, 64'd0);
    q.delete();
    stall_m = 32'd0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain(input logic rdy_always);
    in_valid = 4'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      out_ready = rdy_always ? 1'b1 : ~out_ready;
      tick();
    end
    chk("drain_done", 64'(q.size()), 64'd0);
    out_ready = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1111, 4'b0101, 1'b1, 4, 0};
    vecs[1] = '{4'b1000, 4'b1000, 1'b1, 1, 3};
    vecs[2] = '{4'b0110, 4'b0010, 1'b0, 2, 1};
    vecs[3] = '{4'b1010, 4'b1111, 1'b1, 2, 1};
    vecs[4] = '{4'b0001, 4'b0000, 1'b0, 1, 0};
    vecs[5] = '{4'b0000, 4'b0000, 1'b1, 0, -1};
    stall_m = 32'd0;
    @(negedge clock);

    // Reset state and idle behaviour.
    do_reset();
    chk("rst_address", out_address, 64'd0);
    chk("rst_cycle", out_cycle, 64'd0);
    for (int i = 0; i < 10; i++) tick();

    // Snapshot 1011 at cycle 5, out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && cyc_m != 64'd5; i++) tick();
    chk("cyc_at_5", cyc_m, 64'd5);
    drive_snap(4'b1011, 4'b0010, 0);
    hs_cnt = 0; first_lane = -1;
    tick();
    drain(1'b1);
    chk("t2_records", 64'(hs_cnt), 64'd3);
    tick();

    // Backpressure: lane 0 held, tap stalled for four cycles.
    do_reset();
    out_ready = 1'b0;
    drive_snap(4'b1011, 4'b0000, 2);
    tick();
    for (int i = 0; i < 4; i++) tick();
    #1 chk("t3_stall4", {32'd0, stall_count}, 64'd4);
    drain(1'b1);

    // Back-to-back: B captured on A's final beat.
    out_ready = 1'b1;
    drive_snap(4'b0001, 4'b0000, 3);
    tick();
    drive_snap(4'b0110, 4'b0100, 4);
    #1 chk("t4_ready_last_beat", {63'd0, in_ready}, 64'd1);
    tick();
    drain(1'b1);

    // Reset in the middle of a three-record drain.
    drive_snap(4'b0111, 4'b0000, 5);
    tick();
    in_valid = 4'b0;
    tick();
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    drive_snap(4'b0001, 4'b0001, 6);
    tick();
    drain(1'b1);

    // Stall counter saturation.
    out_ready = 1'b0;
    drive_snap(4'b0001, 4'b0000, 7);
    tick();
    dut.stall_count_r = 32'hFFFF_FFFE;
    stall_m = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) tick();
    #1 chk("t6_saturate", {32'd0, stall_count}, 64'hFFFF_FFFF);
    drain(1'b1);

    // Table of snapshots with different valid masks and ready patterns.
    for (int v = 0; v < 6; v++) begin
      hs_cnt = 0; first_lane = -1;
      out_ready = 1'b1;
      drive_snap(vecs[v].valid, vecs[v].store, 8 + v);
      tick();
      drain(vecs[v].rdy_always);
      chk("vec_count", 64'(hs_cnt), 64'(vecs[v].exp_count));
      chk("vec_first", 64'(first_lane), 64'(vecs[v].exp_first));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_trace_lane_serializer.md
Name: mem_trace_lane_serializer

Overview:
- Controller between a core's multi-lane memory trace tap and a single-record trace logger.
- Captures one snapshot of up to NUM_LANES valid per-lane records, stamps it with a cycle count, then issues the valid lanes one record per handshake in ascending lane order.
- Applies backpressure to the tap and counts the cycles the tap was stalled.

Parameters:
- NUM_LANES, 4: lanes per snapshot; must be at least 1.
- SOURCE_WIDTH, 32: per-lane source ID width.
- DATA_WIDTH, 64: per-lane address, data and cycle-stamp width.
- LOGSIZE_WIDTH, 8: per-lane log2-size width.
- LANE_ID_WIDTH, $clog2(NUM_LANES) with a minimum of 1: width of out_lane_id.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- in_valid  in  NUM_LANES  per-lane valid; LSB is lane 0.
- in_source  in  SOURCE_WIDTH*NUM_LANES  packed per lane, lane 0 in the LSBs; same packing for all packed buses below.
- in_address  in  DATA_WIDTH*NUM_LANES  packed.
- in_is_store  in  NUM_LANES  per-lane store flag.
- in_size  in  LOGSIZE_WIDTH*NUM_LANES  packed.
- in_data  in  DATA_WIDTH*NUM_LANES  packed.
- in_ready  out  1  snapshot accepted this cycle.
- out_valid  out  1  serialized record present.
- out_ready  in  1  logger accepts the record.
- out_cycle  out  DATA_WIDTH  cycle stamp of the snapshot.
- out_lane_id  out  LANE_ID_WIDTH  lane index of the record.
- out_source  out  SOURCE_WIDTH
- out_address  out  DATA_WIDTH
- out_is_store  out  1
- out_size  out  LOGSIZE_WIDTH
- out_data  out  DATA_WIDTH
- busy  out  1  1 while in DRAIN.
- stall_count  out  32  saturating count of stalled tap cycles.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, pending mask=0, cycle_ctr=0, stall_count=0, all held record fields=0. Consequently out_valid=0, busy=0, in_ready=1, all out_* data=0. Reset asserted mid-DRAIN discards pending records without any handshake.
- cycle_ctr: DATA_WIDTH bits, +1 on every clock edge out of reset; wraps from 2^DATA_WIDTH-1 to 0.
- Snapshot fire = (|in_valid) & in_ready. An all-zero in_valid is never captured and does not change state.
- On fire:
  - register all lane fields;
  - pending mask := in_valid;
  - held cycle := cycle_ctr value before that edge;
  - state := DRAIN.
- in_ready = (state==IDLE) | (state==DRAIN & pending has exactly one bit set & out_ready).
  - This allows back-to-back snapshots with zero bubble: a capture on the final drain beat replaces the mask in the same edge.
- State IDLE:
  - out_valid=0.
  - IDLE -> DRAIN on fire.
- State DRAIN:
  - out_valid=1.
  - Selected lane = lowest set bit of pending; out_* present that lane's held fields plus held cycle. out_lane_id = that index.
  - out_valid/out_* are combinational from registers and stable while out_ready=0.
- On out_valid & out_ready: clear the selected bit.
  - If the mask becomes 0 and no fire in the same cycle: DRAIN -> IDLE.
  - If fire in the same cycle: stay in DRAIN with the new mask.
- Drain latency: a snapshot with k valid lanes occupies k cycles of output when out_ready is held 1. The first record is visible the cycle after capture.
- stall_count: +1 each cycle with (|in_valid) & !in_ready; saturates at 2^32-1 and does not wrap.
- out_* data outside DRAIN holds the last registered values; consumers must qualify with out_valid.
- NUM_LANES=1: the pending mask is a single bit and out_lane_id is always 0.

Test Plan:
- Reset, then hold in_valid=0 for 10 cycles -> in_ready=1, out_valid=0, busy=0, stall_count=0.
- in_valid=4'b1011 with address lane n = 0x1000+n at cycle_ctr=5, out_ready=1 -> three records on consecutive cycles with lane_ids 0,1,3, addresses 0x1000/0x1001/0x1003, out_cycle=5 on all; busy falls after the third.
- Same snapshot with out_ready=0 for 4 cycles -> lane 0 record held stable; in_ready=0; if in_valid stays nonzero, stall_count=4; drain then resumes.
- Snapshot A=4'b0001 accepted, snapshot B=4'b0110 presented next cycle with out_ready=1 -> B captured on A's final beat (in_ready=1); lane ids out: 0,1,2 with no bubble; out_cycle for B one greater than for A.
- Assert reset mid-drain after 1 of 3 records -> out_valid=0 and in_ready=1 immediately (asynchronous); the remaining 2 records are never issued; cycle_ctr restarts at 0.
- Force stall_count to 0xFFFFFFFE, then 3 stalled cycles -> reads 0xFFFFFFFF and holds.
